// File: rtl/usb_fifo_stream_reader.sv
// Read-side consumer of the USB CDC FIFO: pops words (1-cycle read latency),
// buffers them in a 2-entry skid buffer and presents a valid/ready stream.
// The MSB of each FIFO word marks end-of-packet; the per-packet word count
// is reported alongside each beat and saturates at 2**LEN_WID-1.
module usb_fifo_stream_reader #(
    parameter int DATA_WID = 9,
    parameter int LEN_WID  = 11
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fifo_empty_i,
    output logic                fifo_pop_o,
    input  logic [DATA_WID-1:0] fifo_data_i,
    output logic [DATA_WID-2:0] data_o,
    output logic                last_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [LEN_WID-1:0]  pktLen_o,
    output logic                pktOvf_o
);

    localparam logic [LEN_WID-1:0] LEN_MAX = '1;

    logic [1:0]          occ;
    logic                inflight;
    logic [DATA_WID-1:0] head;
    logic [DATA_WID-1:0] tail;
    logic [LEN_WID-1:0]  cnt;
    logic [LEN_WID:0]    cnt_inc;
    logic                pop_hs;
    logic                out_hs;
    logic                capture;

    // Pop credit from registered state only: a pop is issued only when the
    // skid buffer can absorb every word already requested plus this one.
    always_comb begin
        fifo_pop_o = !rst_i && (({1'b0, occ} + {2'b00, inflight}) <= 3'd1);
        pop_hs     = fifo_pop_o && !fifo_empty_i;
        capture    = inflight;
        valid_o    = (occ != 2'd0);
        out_hs     = valid_o && ready_i;
        data_o     = head[DATA_WID-2:0];
        last_o     = head[DATA_WID-1];
        cnt_inc    = {1'b0, cnt} + {{LEN_WID{1'b0}}, 1'b1};
        pktLen_o   = (cnt_inc > {1'b0, LEN_MAX}) ? LEN_MAX : cnt_inc[LEN_WID-1:0];
    end

    // Track the word requested last cycle; it arrives on fifo_data_i now.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop_hs;
        end
    end

    // Two-entry skid buffer in FIFO order; head feeds the stream outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            unique case ({capture, out_hs})
                2'b11: begin
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= fifo_data_i;
                    end else begin
                        head <= fifo_data_i;
                    end
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= fifo_data_i;
                    end else begin
                        tail <= fifo_data_i;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Words emitted so far in the current packet, plus sticky overflow flag.
    // A non-last beat that brings the count to the maximum means the packet
    // is longer than the counter can represent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= '0;
            pktOvf_o <= 1'b0;
        end else if (out_hs) begin
            if (last_o) begin
                cnt <= '0;
            end else if (cnt_inc >= {1'b0, LEN_MAX}) begin
                cnt      <= LEN_MAX;
                pktOvf_o <= 1'b1;
            end else begin
                cnt <= cnt_inc[LEN_WID-1:0];
            end
        end
    end

    // A capture into a full buffer that is not draining would lose a word.
    capture_space_a: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(capture && (occ == 2'd2) && !out_hs)
    );

endmodule

// File: tb/tb_usb_fifo_stream_reader.sv
// Scoreboard bench for usb_fifo_stream_reader with a behavioural FIFO source.
module tb_usb_fifo_stream_reader;

    localparam int DW = 9;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_pop_o;
    logic [DW-1:0] fifo_data_i = '0;
    logic [DW-2:0] data_o;
    logic          last_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [LW-1:0] pktLen_o;
    logic          pktOvf_o;

    usb_fifo_stream_reader #(.DATA_WID(DW), .LEN_WID(LW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_pop_o   (fifo_pop_o),
        .fifo_data_i  (fifo_data_i),
        .data_o       (data_o),
        .last_o       (last_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .pktLen_o     (pktLen_o),
        .pktOvf_o     (pktOvf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [2:0] len;
        logic       ovf;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] src_q[$];
    int            checks = 0;
    int            fails = 0;
    int            cyc = 0;
    int            ready_mode = 1;   // 0 low, 1 high, 2 random
    bit            sparse = 1'b0;
    int            pop_cnt = 0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_w = '0;
    int            first_hs = -1;
    bit            seen_valid = 1'b0;

    task automatic load(input logic [DW-1:0] w, input int len, input bit ovf);
        beat_t b;
        b.d   = w[7:0];
        b.l   = w[8];
        b.len = len[2:0];
        b.ovf = ovf;
        src_q.push_back(w);
        exp_q.push_back(b);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats still expected after %0d cycles, required 0", exp_q.size(), limit);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // FIFO source model: data appears the cycle after the pop handshake.
    always @(negedge clk) begin
        cyc++;
        if (pend) begin
            fifo_data_i = pend_w;
            pend = 1'b0;
        end else begin
            fifo_data_i = '0;
        end
        if (ready_mode == 2) ready_i = 1'($urandom_range(0, 1));
        else                 ready_i = (ready_mode == 1);
        fifo_empty_i = (src_q.size() == 0) || (sparse && cyc[0]);
        #1;
        if (rst_i) begin
            checks++;
            if (fifo_pop_o !== 1'b0 || valid_o !== 1'b0 || pktLen_o !== 3'd1 || pktOvf_o !== 1'b0) begin
                fails++;
                $display("FAIL reset: pop=%b valid=%b len=%0d ovf=%b, required pop=0 valid=0 len=1 ovf=0",
                         fifo_pop_o, valid_o, pktLen_o, pktOvf_o);
            end
        end
        if (fifo_pop_o && !fifo_empty_i) begin
            pend   = 1'b1;
            pend_w = src_q.pop_front();
            pop_cnt++;
            if (first_hs < 0) first_hs = cyc;
        end
    end

    // Monitor: compare every accepted beat against the scoreboard head.
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (!rst_i && valid_o && !seen_valid) begin
            seen_valid = 1'b1;
            checks++;
            if (cyc != first_hs + 2) begin
                fails++;
                $display("FAIL latency: first valid in cycle %0d, required %0d", cyc, first_hs + 2);
            end
        end
        if (!rst_i && valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat: unexpected data=%h last=%b, required no beat", data_o, last_o);
            end else begin
                e = exp_q.pop_front();
                if (data_o !== e.d || last_o !== e.l || pktLen_o !== e.len || pktOvf_o !== e.ovf) begin
                    fails++;
                    $display("FAIL beat: got data=%h last=%b len=%0d ovf=%b, required data=%h last=%b len=%0d ovf=%b",
                             data_o, last_o, pktLen_o, pktOvf_o, e.d, e.l, e.len, e.ovf);
                end
            end
        end
    end

    initial begin
        // Reset with FIFO non-empty, then stream one 4-word packet.
        ready_mode = 1;
        load(9'h001, 1, 1'b0);
        load(9'h002, 2, 1'b0);
        load(9'h003, 3, 1'b0);
        load(9'h104, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        drain(100);

        // Back-pressure: only two words may be popped while ready is low.
        ready_mode = 0;
        pop_cnt = 0;
        load(9'h011, 1, 1'b0);
        load(9'h012, 2, 1'b0);
        load(9'h013, 3, 1'b0);
        load(9'h014, 4, 1'b0);
        load(9'h015, 5, 1'b0);
        load(9'h116, 6, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (pop_cnt != 2 || fifo_pop_o !== 1'b0 || valid_o !== 1'b1) begin
            fails++;
            $display("FAIL backpressure: pops=%0d pop=%b valid=%b, required pops=2 pop=0 valid=1",
                     pop_cnt, fifo_pop_o, valid_o);
        end
        ready_mode = 1;
        drain(100);

        // Sparse source with random downstream ready.
        sparse = 1'b1;
        ready_mode = 2;
        load(9'h021, 1, 1'b0);
        load(9'h022, 2, 1'b0);
        load(9'h023, 3, 1'b0);
        load(9'h024, 4, 1'b0);
        load(9'h025, 5, 1'b0);
        load(9'h126, 6, 1'b0);
        drain(300);
        sparse = 1'b0;
        ready_mode = 1;

        // Packet boundary: single-word packet followed by a 3-word packet.
        load(9'h1AA, 1, 1'b0);
        load(9'h0B1, 1, 1'b0);
        load(9'h0B2, 2, 1'b0);
        load(9'h1B3, 3, 1'b0);
        drain(100);

        // Overflow: 9-word packet with a 3-bit counter, then a fresh packet.
        for (int i = 1; i <= 8; i++) begin
            load(9'h0C0 + 9'(i), (i < 7) ? i : 7, (i >= 8));
        end
        load(9'h1C9, 7, 1'b1);
        load(9'h1D0, 1, 1'b1);
        drain(150);

        checks++;
        if (pktOvf_o !== 1'b1 || pktLen_o !== 3'd1) begin
            fails++;
            $display("FAIL ovf_sticky: ovf=%b len=%0d, required ovf=1 len=1", pktOvf_o, pktLen_o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
